// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage RV32I pipeline.
// Sole driver of the regfile write port. Non-loads write one cycle after
// transfer. Loads wait in WAIT_MEM for the data response, which is then
// aligned and extended before the write. Writes to x0 are suppressed.
// Optional feature macro: WB_LOAD_TIMEOUT_EN. When it is defined, a load that
// gets no response within TIMEOUT_CYCLES is abandoned and wb_err is set.
module wb_stage #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_ld_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wb_err
);

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    state_t            r_state;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [2:0]        r_ld_type;
    logic [1:0]        r_addr_lo;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_data;

    // WB accepts a new instruction only while idle.
    assign mem_ready = (r_state == S_IDLE);

    // Pick the addressed byte/halfword from the response word, then extend it
    // according to the captured funct3. Undefined encodings behave like LW.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'd0: w_byte = dresp_data[7:0];
            2'd1: w_byte = dresp_data[15:8];
            2'd2: w_byte = dresp_data[23:16];
            2'd3: w_byte = dresp_data[31:24];
            default: w_byte = dresp_data[7:0];
        endcase
        w_half = r_addr_lo[1] ? dresp_data[31:16] : dresp_data[15:0];
        case (r_ld_type)
            3'b000:  w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
            3'b001:  w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b101:  w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
            default: w_ld_data = dresp_data;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Writeback FSM with load timeout: retire non-loads, track pending load,
    // abandon it if no response arrives in time. A response in the expiry
    // cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            wb_err    <= 1'b0;
            r_wreg    <= 1'b0;
            r_wd      <= '0;
            r_ld_type <= '0;
            r_addr_lo <= '0;
            r_cnt     <= '0;
        end else begin
            we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (!mem_is_load) begin
                            if (mem_wreg && (mem_wd != '0)) begin
                                we    <= 1'b1;
                                waddr <= mem_wd;
                                wdata <= mem_wdata;
                            end
                        end else begin
                            r_wreg    <= mem_wreg;
                            r_wd      <= mem_wd;
                            r_ld_type <= mem_ld_type;
                            r_addr_lo <= mem_addr_lo;
                            r_cnt     <= '0;
                            r_state   <= S_WAIT_MEM;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (dresp_valid) begin
                        if (r_wreg && (r_wd != '0)) begin
                            we    <= 1'b1;
                            waddr <= r_wd;
                            wdata <= w_ld_data;
                        end
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        wb_err  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    // Timeout disabled: loads wait indefinitely and no error is ever raised.
    assign wb_err = 1'b0;

    // Writeback FSM: retire non-loads immediately, hold a load until its
    // response arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            r_wreg    <= 1'b0;
            r_wd      <= '0;
            r_ld_type <= '0;
            r_addr_lo <= '0;
        end else begin
            we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (!mem_is_load) begin
                            if (mem_wreg && (mem_wd != '0)) begin
                                we    <= 1'b1;
                                waddr <= mem_wd;
                                wdata <= mem_wdata;
                            end
                        end else begin
                            r_wreg    <= mem_wreg;
                            r_wd      <= mem_wd;
                            r_ld_type <= mem_ld_type;
                            r_addr_lo <= mem_addr_lo;
                            r_state   <= S_WAIT_MEM;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (dresp_valid) begin
                        if (r_wreg && (r_wd != '0)) begin
                            we    <= 1'b1;
                            waddr <= r_wd;
                            wdata <= w_ld_data;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected regfile writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_wreg = 1'b0;
    logic [4:0]  mem_wd = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_is_load = 1'b0;
    logic [2:0]  mem_ld_type = '0;
    logic [1:0]  mem_addr_lo = '0;
    logic        dresp_valid = 1'b0;
    logic [31:0] dresp_data = '0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_err;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_is_load(mem_is_load), .mem_ld_type(mem_ld_type),
        .mem_addr_lo(mem_addr_lo),
        .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .we(we), .waddr(waddr), .wdata(wdata), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && we) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=%h, expected no write", waddr, wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (waddr !== e.a || wdata !== e.d) begin
                    n_err++;
                    $display("FAIL write: got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                             waddr, wdata, e.a, e.d);
                end
            end
        end
    end

    // One-cycle transfer starting at posedge+1; returns at posedge+1.
    task automatic send(input logic wreg, input logic [4:0] wd, input logic [31:0] d,
                        input logic ld, input logic [2:0] lt, input logic [1:0] alo);
        chk("mem_ready_before_xfer", {31'b0, mem_ready}, 32'd1);
        mem_valid = 1'b1; mem_wreg = wreg; mem_wd = wd; mem_wdata = d;
        mem_is_load = ld; mem_ld_type = lt; mem_addr_lo = alo;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_is_load = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a; e.d = d;
        q.push_back(e);
    endtask

    // Load with wcyc empty wait cycles, then the response.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] alo,
                           input int wcyc, input logic [31:0] rdata, input logic [31:0] exp_d,
                           input logic exp_wr);
        send(1'b1, rd, 32'hDEADBEEF, 1'b1, lt, alo);
        for (int i = 0; i < wcyc; i++) begin
            chk("mem_ready_wait", {31'b0, mem_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mem_ready_wait", {31'b0, mem_ready}, 32'd0);
        if (exp_wr) push(rd, exp_d);
        dresp_valid = 1'b1; dresp_data = rdata;
        @(posedge clk); #1;
        dresp_valid = 1'b0;
        chk("mem_ready_after_resp", {31'b0, mem_ready}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_waddr", {27'b0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wb_err", {31'b0, wb_err}, 32'd0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back non-loads.
        push(5'd5, 32'h11111111);
        send(1'b1, 5'd5, 32'h11111111, 1'b0, 3'b000, 2'd0);
        push(5'd6, 32'h22222222);
        send(1'b1, 5'd6, 32'h22222222, 1'b0, 3'b000, 2'd0);
        chk("mem_ready_b2b", {31'b0, mem_ready}, 32'd1);

        // x0 and wreg=0 writes suppressed; waddr/wdata hold.
        send(1'b1, 5'd0, 32'h33333333, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        chk("x0_no_we", {31'b0, we}, 32'd0);
        chk("x0_hold_wdata", wdata, 32'h22222222);
        @(posedge clk); #1;
        send(1'b0, 5'd9, 32'h44444444, 1'b0, 3'b000, 2'd0);

        // Loads: alignment and extension.
        do_load(5'd7, 3'b000, 2'd2, 3, 32'h12F03456, 32'hFFFFFFF0, 1'b1);
        do_load(5'd7, 3'b100, 2'd2, 3, 32'h12F03456, 32'h000000F0, 1'b1);
        do_load(5'd8, 3'b001, 2'd2, 1, 32'h80017FFF, 32'hFFFF8001, 1'b1);
        do_load(5'd8, 3'b101, 2'd2, 0, 32'h80017FFF, 32'h00008001, 1'b1);
        do_load(5'd9, 3'b010, 2'd3, 2, 32'h80017FFF, 32'h80017FFF, 1'b1);
        do_load(5'd10, 3'b000, 2'd0, 0, 32'h80017FFF, 32'hFFFFFFFF, 1'b1);
        do_load(5'd11, 3'b100, 2'd1, 1, 32'h80017FFF, 32'h0000007F, 1'b1);
        do_load(5'd12, 3'b001, 2'd1, 0, 32'h80017FFF, 32'h00007FFF, 1'b1);
        do_load(5'd13, 3'b111, 2'd1, 0, 32'hA5C3E1F0, 32'hA5C3E1F0, 1'b1);
        do_load(5'd0, 3'b010, 2'd0, 1, 32'hCAFEF00D, 32'h0, 1'b0);

        // Stray response while idle: no write.
        dresp_valid = 1'b1; dresp_data = 32'h55555555;
        @(posedge clk); #1 dresp_valid = 1'b0;
        chk("idle_resp_no_we", {31'b0, we}, 32'd0);

        // Reset during WAIT_MEM drops the pending load.
        send(1'b1, 5'd14, 32'h0, 1'b1, 3'b010, 2'd0);
        @(posedge clk); #1 rst = 1'b0;
        #2 rst = 1'b1;
        #1 chk("ready_after_rst", {31'b0, mem_ready}, 32'd1);
        dresp_valid = 1'b1; dresp_data = 32'h66666666;
        @(posedge clk); #1 dresp_valid = 1'b0;
        chk("no_we_after_rst", {31'b0, we}, 32'd0);
        @(posedge clk); #1;

`ifdef WB_LOAD_TIMEOUT_EN
        // Response on the expiry cycle wins.
        do_load(5'd15, 3'b010, 2'd0, 3, 32'h77777777, 32'h77777777, 1'b1);
        chk("resp_at_expiry_err", {31'b0, wb_err}, 32'd0);
        // No response: abandoned after 4 cycles.
        send(1'b1, 5'd16, 32'h0, 1'b1, 3'b010, 2'd0);
        repeat (3) @(posedge clk);
        #1 chk("err_before_expiry", {31'b0, wb_err}, 32'd0);
        @(posedge clk); #1;
        chk("timeout_err", {31'b0, wb_err}, 32'd1);
        chk("timeout_ready", {31'b0, mem_ready}, 32'd1);
        @(posedge clk); #1;
        chk("timeout_sticky", {31'b0, wb_err}, 32'd1);
`else
        chk("wb_err_tied", {31'b0, wb_err}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
